pred_mask_stack: RTL
====================

Name: pred_mask_stack

Overview:
- Per-SM predicate/divergence stack that consumes the scheduler control unit's pstack_push / pstack_pop / pstack_complement strobes.
- Drives the per-lane active mask to the SP cores' register-write and memory enables.
- Returns all_mask_true / all_mask_false to the control unit so it can take branch-skip decisions (IF_P / ELSE_P / WHILE_P) in the same cycle as the stack operation.

Parameters:
- N_CORES, 4, number of SP lanes; width of all masks.
- DEPTH, 8, maximum nesting levels stored above the base level.
- DW, $clog2(DEPTH+1), width of the depth counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears stack.
- core_enable  input  N_CORES  base (level-0) lane mask; used combinationally.
- pred_in  input  N_CORES  per-lane SETP predicate result, valid while pstack_push is high.
- pstack_push  input  1  push a new predicate level.
- pstack_pop  input  1  discard top level.
- pstack_complement  input  1  switch top level to its else-branch.
- active_mask  output  N_CORES  current lane enable (top level, or core_enable at depth 0).
- all_mask_true  output  1  every lane active in parent level has predicate 1.
- all_mask_false  output  1  no lane active in parent level has predicate 1.
- depth  output  DW  current nesting depth.
- overflow_err  output  1  sticky; push attempted at depth==DEPTH.
- underflow_err  output  1  sticky; pop or complement attempted at depth==0.

Behaviour:
Storage and reset
- Storage: mask[1..DEPTH], N_CORES bits each. Level 0 is core_enable and is never stored.
- Reset (async): depth=0, both error flags=0, all mask entries=0.
- Reset values of outputs: active_mask=core_enable, all_mask_true=1, all_mask_false=0.

Operations (take effect at rising edge)
- push, with depth<DEPTH: mask[depth+1] <= pred_in & M_top; depth <= depth+1. M_top is the active mask before the edge.
- pop, with depth>0: depth <= depth-1. The entry is not cleared.
- complement, with depth>0: mask[depth] <= M_par & ~mask[depth]. M_par is level depth-1, i.e. core_enable when depth==1.
- Push at depth==DEPTH: no state change except overflow_err <= 1.
- Pop or complement at depth==0: no state change except underflow_err <= 1.
- Error flags clear only on reset.

Multiple strobes in one cycle
- Illegal; the control unit never issues this.
- Priority is push > complement > pop. Only the winner executes; losers are dropped silently.

Flags (combinational, same cycle as the strobe)
- Define a pending predicate P and parent M:
  - pstack_push high: P = pred_in & M_top, M = M_top (look-ahead of the level being pushed).
  - otherwise at depth>0: P = mask[depth], M = level depth-1.
  - otherwise at depth==0: P = M = core_enable.
- all_mask_false = (P == 0).
- all_mask_true = (P == M).
- With M==0, both flags are 1.
- Look-ahead applies to push only. The flags during a complement or pop cycle reflect the pre-edge top.
- This lets the control unit sample the flags at the same edge as its push (IF_P) and in the following state (WHILE_P_1, ELSE_P).

Outputs and timing
- active_mask = (depth==0) ? core_enable : mask[depth]. Combinational from registered state, so the new mask is visible the cycle after the strobe.
- Latency: 1 cycle for every operation; no stalls; no handshake beyond the strobes.
- Reset asserted mid-operation wins immediately; a strobe in the reset cycle is lost.

Decomposition:
- Shared defines header holds the PSTACK depth default and N_CORES, the same value the SM core and ALU array use.
- No package typedefs are needed.
- One natural combinational sub-module: pred_flag_eval (inputs P and M; outputs all_mask_true and all_mask_false), reusable by a future warp scheduler.
- The stack array and depth counter stay in pred_mask_stack.

Test Plan (N_CORES=4, DEPTH=8, core_enable=4'b1111):
- Reset mid-run -> depth=0, active_mask=1111, all_mask_true=1, all_mask_false=0, errors=0.
- push with pred_in=0101 -> flags in push cycle: true=0, false=0. Next cycle: active_mask=0101, depth=1. Then complement -> active_mask=1010. Then pop -> active_mask=1111, depth=0.
- Nested: push 0111, then push with pred_in=1000 -> all_mask_false=1 during the second push. After the edge: active_mask=0000, depth=2.
- push with pred_in=1111 -> all_mask_true=1 in that cycle. complement -> active_mask=0000. pop -> active_mask=1111.
- 9 consecutive pushes -> depth saturates at 8, overflow_err=1, active_mask unchanged by the 9th push. Then pop at depth 0 after 8 pops -> underflow_err=1, depth stays 0.
- push and pop asserted together at depth=1 (mask 0011) with pred_in=0001 -> push wins: depth=2, active_mask=0001.

Source files
------------

// File: rtl/pred_mask_stack_pkg.sv
// Shared SM-wide sizing constants: lane count and predicate stack depth.
// The SM core and ALU array import the same values.
package pred_mask_stack_pkg;

  localparam int unsigned NCores      = 4;
  localparam int unsigned PStackDepth = 8;

endpackage

// File: rtl/pred_mask_stack_if.sv
// Control-unit <-> predicate stack bus: strobes and lane masks in, active mask and flags out.
interface pred_mask_stack_if
  import pred_mask_stack_pkg::*;
#(
  parameter int unsigned N_CORES = NCores,
  parameter int unsigned DW      = $clog2(PStackDepth + 1)
);

  logic [N_CORES-1:0] core_enable;
  logic [N_CORES-1:0] pred_in;
  logic               pstack_push;
  logic               pstack_pop;
  logic               pstack_complement;
  logic [N_CORES-1:0] active_mask;
  logic               all_mask_true;
  logic               all_mask_false;
  logic [DW-1:0]      depth;
  logic               overflow_err;
  logic               underflow_err;

  modport master (
    output core_enable, pred_in, pstack_push, pstack_pop, pstack_complement,
    input  active_mask, all_mask_true, all_mask_false, depth, overflow_err, underflow_err
  );

  modport slave (
    input  core_enable, pred_in, pstack_push, pstack_pop, pstack_complement,
    output active_mask, all_mask_true, all_mask_false, depth, overflow_err, underflow_err
  );

endinterface

// File: rtl/pred_flag_eval.sv
// Branch-skip flags: compares a pending predicate against its parent lane mask.
module pred_flag_eval #(
  parameter int unsigned N_CORES = 4
) (
  input  logic [N_CORES-1:0] i_pred,
  input  logic [N_CORES-1:0] i_parent,
  output logic               o_all_true,
  output logic               o_all_false
);

  assign o_all_false = (i_pred == '0);
  assign o_all_true  = (i_pred == i_parent);

endmodule

// File: rtl/pred_mask_stack.sv
// Per-SM predicate/divergence stack. Level 0 is core_enable; levels 1..DEPTH are stored,
// entry i of r_mask holds level i+1.
module pred_mask_stack
  import pred_mask_stack_pkg::*;
#(
  parameter int unsigned N_CORES = NCores,
  parameter int unsigned DEPTH   = PStackDepth,
  parameter int unsigned DW      = $clog2(DEPTH + 1)
) (
  input logic              clk,
  input logic              reset,
  pred_mask_stack_if.slave bus
);

  logic [N_CORES-1:0] r_mask [DEPTH];
  logic [DW-1:0]      r_depth;
  logic               r_ovf;
  logic               r_unf;

  logic [N_CORES-1:0] w_top;
  logic [N_CORES-1:0] w_par;
  logic [N_CORES-1:0] w_p;
  logic [N_CORES-1:0] w_m;
  logic               w_at_max;
  logic               w_at_zero;
  logic               w_do_push;
  logic               w_do_comp;
  logic               w_do_pop;

  // Level lookup by compare rather than indexing keeps level 0 out of the array.
  always_comb begin
    w_top = bus.core_enable;
    w_par = bus.core_enable;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (r_depth == DW'(i + 1)) w_top = r_mask[i];
    end
    for (int i = 0; i + 1 < int'(DEPTH); i++) begin
      if (r_depth == DW'(i + 2)) w_par = r_mask[i];
    end
  end

  // Strobe priority: push > complement > pop.
  always_comb begin
    w_at_max  = (r_depth == DW'(DEPTH));
    w_at_zero = (r_depth == '0);
    w_do_push = bus.pstack_push & ~w_at_max;
    w_do_comp = ~bus.pstack_push & bus.pstack_complement & ~w_at_zero;
    w_do_pop  = ~bus.pstack_push & ~bus.pstack_complement & bus.pstack_pop & ~w_at_zero;
  end

  // Push looks ahead at the level about to be created.
  always_comb begin
    w_p = bus.core_enable;
    w_m = bus.core_enable;
    if (bus.pstack_push) begin
      w_p = bus.pred_in & w_top;
      w_m = w_top;
    end else if (!w_at_zero) begin
      w_p = w_top;
      w_m = w_par;
    end
  end

  pred_flag_eval #(
    .N_CORES (N_CORES)
  ) u_flag_eval (
    .i_pred      (w_p),
    .i_parent    (w_m),
    .o_all_true  (bus.all_mask_true),
    .o_all_false (bus.all_mask_false)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) r_mask[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (w_do_push && r_depth == DW'(i)) begin
          r_mask[i] <= bus.pred_in & w_top;
        end else if (w_do_comp && r_depth == DW'(i + 1)) begin
          r_mask[i] <= w_par & ~r_mask[i];
        end
      end
      if (w_do_push) begin
        r_depth <= r_depth + DW'(1);
      end else if (w_do_pop) begin
        r_depth <= r_depth - DW'(1);
      end
      if (bus.pstack_push && w_at_max) r_ovf <= 1'b1;
      if (!bus.pstack_push && (bus.pstack_complement || bus.pstack_pop) && w_at_zero) begin
        r_unf <= 1'b1;
      end
    end
  end

  assign bus.active_mask   = w_top;
  assign bus.depth         = r_depth;
  assign bus.overflow_err  = r_ovf;
  assign bus.underflow_err = r_unf;

endmodule
